// File: rtl/nibble_serial_add_ctrl.sv
// Purpose: WIDTH-bit adder that reuses one 4-bit ripple slice, one nibble per cycle, LSB first.
// Latency: result valid NIBBLES cycles after accept; accept-to-accept is NIBBLES+2 cycles minimum.
// Backpressure: result held in HOLD until out_ready; no new operand is accepted until then.
// Optional: define ADD_SUB_EN to add a 'sub' port (a - b via inverted b and an initial carry of 1).
module nibble_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             carry;
    logic [CNT_W-1:0] count;
    logic             accept;
    logic             last_nib;
    logic [3:0]       b_nib;
    logic [4:0]       slice;
    logic [WIDTH+3:0] sum_shift;
`ifdef ADD_SUB_EN
    logic             sub_r;
`endif

    // The single shared slice: 4-bit operands plus carry-in, 5-bit result so nothing is lost.
`ifdef ADD_SUB_EN
    assign b_nib = sub_r ? ~b_sr[3:0] : b_sr[3:0];
`else
    assign b_nib = b_sr[3:0];
`endif
    assign slice     = {1'b0, a_sr[3:0]} + {1'b0, b_nib} + {4'd0, carry};
    // New nibble enters at the MSB end; after NIBBLES shifts the LSB nibble has reached bit 0.
    assign sum_shift = {slice[3:0], sum};
    assign last_nib  = (count == LAST_CNT);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs; reset forces all handshakes low.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !rst;
                accept   = in_valid && !rst;
                if (accept) state_nxt = RUN;
            end
            RUN: begin
                busy = !rst;
                if (last_nib) state_nxt = HOLD;
            end
            HOLD: begin
                out_valid = !rst;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, per-nibble shift/accumulate and carry bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr  <= '0;
            b_sr  <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            carry <= 1'b0;
            count <= '0;
`ifdef ADD_SUB_EN
            sub_r <= 1'b0;
`endif
        end else if (accept) begin
            a_sr  <= a;
            b_sr  <= b;
            count <= '0;
`ifdef ADD_SUB_EN
            sub_r <= sub;
            carry <= sub;
`else
            carry <= 1'b0;
`endif
        end else if (state == RUN) begin
            sum   <= sum_shift[WIDTH+3:4];
            carry <= slice[4];
            a_sr  <= a_sr >> 4;
            b_sr  <= b_sr >> 4;
            // A single-nibble build has nothing to count.
            count <= (NIBBLES == 1) ? '0 : count + 1'b1;
            if (last_nib) cout <= slice[4];
        end
    end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
module tb_nibble_serial_add_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid16, in_ready16, out_valid16, out_ready16, cout16, busy16;
    logic [15:0] a16, b16, sum16;
    logic        in_valid4, in_ready4, out_valid4, out_ready4, cout4, busy4;
    logic [3:0]  a4, b4, sum4;
`ifdef ADD_SUB_EN
    logic        sub16, sub4;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    nibble_serial_add_ctrl #(.WIDTH(16)) u16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16),
`ifdef ADD_SUB_EN
        .sub(sub16),
`endif
        .out_valid(out_valid16), .out_ready(out_ready16),
        .sum(sum16), .cout(cout16), .busy(busy16)
    );

    nibble_serial_add_ctrl #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4),
`ifdef ADD_SUB_EN
        .sub(sub4),
`endif
        .out_valid(out_valid4), .out_ready(out_ready4),
        .sum(sum4), .cout(cout4), .busy(busy4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present operands for one edge on the 16-bit instance (expected to be IDLE).
    task automatic accept16(input logic [15:0] av, input logic [15:0] bv, input logic s);
        a16 = av;
        b16 = bv;
`ifdef ADD_SUB_EN
        sub16 = s;
`endif
        in_valid16 = 1'b1;
        step();
        in_valid16 = 1'b0;
    endtask

    // Full operation with out_ready high: checks latency, result and return to IDLE.
    task automatic run16(input string tag, input logic [15:0] av, input logic [15:0] bv,
                         input logic s, input logic [15:0] exp_sum, input logic exp_cout);
        out_ready16 = 1'b1;
        chk({tag, "_in_ready_before"}, 32'(in_ready16), 32'd1);
        accept16(av, bv, s);
        chk({tag, "_busy_run"}, 32'(busy16), 32'd1);
        step(3);
        chk({tag, "_out_valid_early"}, 32'(out_valid16), 32'd0);
        step();
        chk({tag, "_out_valid"}, 32'(out_valid16), 32'd1);
        chk({tag, "_sum"}, 32'(sum16), 32'(exp_sum));
        chk({tag, "_cout"}, 32'(cout16), 32'(exp_cout));
        step();
        chk({tag, "_idle_in_ready"}, 32'(in_ready16), 32'd1);
        chk({tag, "_idle_out_valid"}, 32'(out_valid16), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        in_valid16 = 1'b0; out_ready16 = 1'b0; a16 = '0; b16 = '0;
        in_valid4  = 1'b0; out_ready4  = 1'b0; a4  = '0; b4  = '0;
`ifdef ADD_SUB_EN
        sub16 = 1'b0; sub4 = 1'b0;
`endif
        step(2);

        // Reset state
        chk("rst_in_ready", 32'(in_ready16), 32'd0);
        chk("rst_out_valid", 32'(out_valid16), 32'd0);
        chk("rst_busy", 32'(busy16), 32'd0);
        chk("rst_sum", 32'(sum16), 32'd0);
        chk("rst_cout", 32'(cout16), 32'd0);
        rst = 1'b0;
        step();
        chk("rel_in_ready", 32'(in_ready16), 32'd1);
        chk("rel_in_ready4", 32'(in_ready4), 32'd1);

        // Basic add, no carries
        run16("t1", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);

        // Carry ripples through every nibble
        run16("t2", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);

        // Consumer stalls: result held, extra in_valid ignored
        out_ready16 = 1'b0;
        accept16(16'h000F, 16'h0001, 1'b0);
        step(4);
        for (int i = 0; i < 5; i++) begin
            in_valid16 = (i % 2 == 0);
            a16 = 16'hAAAA;
            b16 = 16'h5555;
            chk("t3_hold_valid", 32'(out_valid16), 32'd1);
            chk("t3_hold_sum", 32'(sum16), 32'h0010);
            chk("t3_hold_cout", 32'(cout16), 32'd0);
            chk("t3_hold_in_ready", 32'(in_ready16), 32'd0);
            step();
        end
        in_valid16 = 1'b0;
        chk("t3_still_held", 32'(sum16), 32'h0010);
        out_ready16 = 1'b1;
        step();
        chk("t3_released_valid", 32'(out_valid16), 32'd0);
        chk("t3_released_in_ready", 32'(in_ready16), 32'd1);
        chk("t3_no_phantom_busy", 32'(busy16), 32'd0);

        // Reset during the second RUN cycle aborts the operation
        accept16(16'hFFFF, 16'hFFFF, 1'b0);
        step();
        chk("t4_busy_mid", 32'(busy16), 32'd1);
        rst = 1'b1;
        step();
        chk("t4_out_valid", 32'(out_valid16), 32'd0);
        chk("t4_sum", 32'(sum16), 32'd0);
        chk("t4_cout", 32'(cout16), 32'd0);
        chk("t4_busy", 32'(busy16), 32'd0);
        chk("t4_in_ready", 32'(in_ready16), 32'd0);
        rst = 1'b0;
        step();
        run16("t4b", 16'h0101, 16'h0202, 1'b0, 16'h0303, 1'b0);

`ifdef ADD_SUB_EN
        // Subtraction: cout=1 means no borrow
        run16("t5a", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0);
        run16("t5b", 16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1);
        run16("t5c", 16'h0007, 16'h0005, 1'b0, 16'h000C, 1'b0);
`endif

        // Single-nibble build: one RUN cycle
        out_ready4 = 1'b1;
        a4 = 4'h9;
        b4 = 4'h8;
`ifdef ADD_SUB_EN
        sub4 = 1'b0;
`endif
        in_valid4 = 1'b1;
        step();
        in_valid4 = 1'b0;
        chk("t6_busy", 32'(busy4), 32'd1);
        chk("t6_out_valid_early", 32'(out_valid4), 32'd0);
        step();
        chk("t6_out_valid", 32'(out_valid4), 32'd1);
        chk("t6_sum", 32'(sum4), 32'h1);
        chk("t6_cout", 32'(cout4), 32'd1);
        step();
        chk("t6_in_ready", 32'(in_ready4), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
